prog_loader: RTL and testbench

- Upstream boot stage for the Proc core: consumes a byte stream (UART RX or host FIFO) and writes instruction words into Proc's instruction memory.
- Drives Proc's a/d/we load interface, then raises exec to start execution.
- Replaces hand-driven load sequencing with a self-contained, length-framed loader FSM.

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_byte_packer.sv | 37 +++
 rtl/prog_loader.sv | 149 ++++++++++++++
 tb/tb_prog_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the length-framed instruction loader.
package prog_loader_pkg;

   localparam int LEN_W          = 16;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_BYTE,
      S_WRITE,
      S_CSUM,
      S_RUN,
      S_ERR
   } state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles bytes MSB-first into a word; o_word/o_word_ready are combinational with the
// final byte so the word is usable on the same edge. Shifts only when i_shift is high.
module byte_packer
   import prog_loader_pkg::*;
#(
   parameter int WORD_W = BYTE_W * BYTES_PER_WORD
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic              i_shift,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [WORD_W-1:0] o_word,
   output logic              o_word_ready
);

   localparam int CNT_W = $clog2(BYTES_PER_WORD);
   localparam int KEEP_W = WORD_W - BYTE_W;

   logic [KEEP_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_cnt;

   // Only the leading bytes are stored; the last byte is taken straight from the input.
   assign o_word       = {r_shift, i_byte};
   assign o_word_ready = i_shift && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_shift) begin
         r_shift <= o_word[KEEP_W-1:0];
         r_cnt   <= o_word_ready ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Length-framed boot loader: bytes in, one write strobe the cycle after each 4th byte, then exec.
// in_ready drops during writes and after the frame ends; PROG_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 32,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] a,
   output logic [DATA_W-1:0] d,
   output logic              we,
   output logic              exec,
   output logic              err
);

   localparam logic [LEN_W:0] DEPTH = (LEN_W + 1)'(2 ** ADDR_W);

   state_t              r_state;
   state_t              w_state_nxt;
   state_t              w_after_data;
   logic [BYTE_W-1:0]   r_len_hi;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_word_idx;
   logic [ADDR_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_d;
   logic [LEN_W-1:0]    w_len;
   logic                w_xfer;
   logic                w_more;
   logic [DATA_W-1:0]   w_word;
   logic                w_word_ready;

   assign w_xfer = in_valid && in_ready;
   assign w_len  = {r_len_hi, in_data};
   assign w_more = (r_word_idx + LEN_W'(1)) < r_len;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] r_csum;

   assign w_after_data = S_CSUM;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_csum <= '0;
      end else if (w_xfer && (r_state != S_CSUM)) begin
         r_csum <= r_csum ^ in_data;
      end
   end
`else
   assign w_after_data = S_RUN;
`endif

   byte_packer #(
      .WORD_W (DATA_W)
   ) u_packer (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_clr        ((r_state == S_LEN_LO) && w_xfer),
      .i_shift      ((r_state == S_BYTE) && w_xfer),
      .i_byte       (in_data),
      .o_word       (w_word),
      .o_word_ready (w_word_ready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_LEN_HI;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      we          = 1'b0;
      exec        = 1'b0;
      err         = 1'b0;
      case (r_state)
         S_LEN_HI: begin
            in_ready = 1'b1;
            if (w_xfer) w_state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            in_ready = 1'b1;
            if (w_xfer) begin
               if ({1'b0, w_len} > DEPTH)  w_state_nxt = S_ERR;
               else if (w_len == '0)       w_state_nxt = w_after_data;
               else                        w_state_nxt = S_BYTE;
            end
         end
         S_BYTE: begin
            in_ready = 1'b1;
            if (w_word_ready) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            we          = 1'b1;
            w_state_nxt = w_more ? S_BYTE : w_after_data;
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CSUM: begin
            in_ready = 1'b1;
            if (w_xfer) w_state_nxt = (in_data == r_csum) ? S_RUN : S_ERR;
         end
`endif
         S_RUN:   exec = 1'b1;
         S_ERR:   err  = 1'b1;
         default: w_state_nxt = r_state;
      endcase
      // Reset forces every output low in the reset cycle itself.
      if (rst) begin
         in_ready = 1'b0;
         we       = 1'b0;
         exec     = 1'b0;
         err      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_len_hi   <= '0;
         r_len      <= '0;
         r_word_idx <= '0;
         r_a        <= '0;
         r_d        <= '0;
      end else begin
         if ((r_state == S_LEN_HI) && w_xfer) r_len_hi <= in_data;
         if ((r_state == S_LEN_LO) && w_xfer) begin
            r_len      <= w_len;
            r_word_idx <= '0;
         end
         // Address and data are captured with the last byte so they are valid during the strobe.
         if (w_word_ready) begin
            r_a <= ADDR_W'(BASE_ADDR) + r_word_idx[ADDR_W-1:0];
            r_d <= w_word;
         end
         if (r_state == S_WRITE) r_word_idx <= r_word_idx + LEN_W'(1);
      end
   end

   assign a = rst ? '0 : r_a;
   assign d = rst ? '0 : r_d;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: randomized frames and gaps against a frame-level model.
`timescale 1ns/1ps
module tb_prog_loader;

   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 32;
   localparam int BASE_ADDR = 0;
   localparam int DEPTH     = 1 << ADDR_W;
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [ADDR_W-1:0] a;
   logic [DATA_W-1:0] d;
   logic              we;
   logic              exec;
   logic              err;

   prog_loader #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BASE_ADDR (BASE_ADDR)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .d        (d),
      .we       (we),
      .exec     (exec),
      .err      (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   wr_t         sb[$];
   wr_t         exp_w;
   logic [31:0] frame_words[$];
   int          tests = 0;
   int          fails = 0;
   int          we_cnt = 0;
   int          last_we_cyc = 0;
   int          exec_cyc = 0;
   int          err_cyc = 0;
   int          last_xfer_cyc = 0;
   bit          exec_seen = 1'b0;
   bit          err_seen = 1'b0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every write strobe must match the next expected write.
   always @(negedge clk) begin
      if (!rst) begin
         if (we) begin
            we_cnt++;
            last_we_cyc = cyc;
            chk("in_ready_during_we", {63'd0, in_ready}, 64'd0);
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_we: got a=0x%0h d=0x%0h, expected no write", a, d);
            end else begin
               exp_w = sb.pop_front();
               chk("we_addr", 64'(a), 64'(exp_w.a));
               chk("we_data", 64'(d), 64'(exp_w.d));
            end
         end
         if (exec && !exec_seen) begin
            exec_seen = 1'b1;
            exec_cyc  = cyc;
         end
         if (err && !err_seen) begin
            err_seen = 1'b1;
            err_cyc  = cyc;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_a",        64'(a),        64'd0);
      chk("rst_d",        64'(d),        64'd0);
      chk("rst_we",       64'(we),       64'd0);
      chk("rst_exec",     64'(exec),     64'd0);
      chk("rst_err",      64'(err),      64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      sb.delete();
      we_cnt    = 0;
      exec_seen = 1'b0;
      err_seen  = 1'b0;
      #1;
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      bit got;
      got      = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      for (int n = 0; n < 50 && !got; n++) begin
         got = in_ready;
         @(negedge clk);
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL byte_accept_timeout: byte 0x%0h not accepted, expected accept within 50 cycles", b);
      end
      last_xfer_cyc = cyc;
      in_valid = 1'b0;
      in_data  = $urandom_range(0, 255);
   endtask

   task automatic send_g(input logic [7:0] b, input int max_gap);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(b);
   endtask

   task automatic run_frame(input int len, input int max_gap, input bit good_csum);
      logic [15:0] l16;
      logic [7:0]  cs;
      logic [31:0] wd;
      bit          exp_err;
      int          nexp;
      int          exp_exec_cyc;
      wr_t         w;
      l16 = len[15:0];
      cs  = 8'h00;
      send_g(l16[15:8], max_gap);
      cs ^= l16[15:8];
      send_g(l16[7:0], max_gap);
      cs ^= l16[7:0];
      exp_err = (len > DEPTH);
      nexp    = exp_err ? 0 : len;
      for (int i = 0; i < nexp; i++) begin
         w.a = ADDR_W'((BASE_ADDR + i) % DEPTH);
         w.d = frame_words[i];
         sb.push_back(w);
         wd = frame_words[i];
         for (int k = 3; k >= 0; k--) begin
            send_g(wd[8*k +: 8], max_gap);
            cs ^= wd[8*k +: 8];
         end
      end
      if (CSUM_EN && !exp_err) begin
         send_g(good_csum ? cs : (cs ^ 8'h01), max_gap);
         if (!good_csum) exp_err = 1'b1;
      end
      for (int n = 0; n < 50 && !exec_seen && !err_seen; n++) @(negedge clk);
      repeat (6) @(negedge clk);
      chk("exec_seen", 64'(exec_seen), 64'(!exp_err));
      chk("err_seen",  64'(err_seen),  64'(exp_err));
      chk("we_count",  64'(we_cnt),    64'(nexp));
      chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("exec_held", 64'(exec), 64'(!exp_err));
      chk("err_held",  64'(err),  64'(exp_err));
      chk("ready_low_after_frame", 64'(in_ready), 64'd0);
      if (exp_err) begin
         chk("err_cycle", 64'(err_cyc), 64'(last_xfer_cyc));
      end else begin
         exp_exec_cyc = last_xfer_cyc + ((nexp > 0 && !CSUM_EN) ? 1 : 0);
         chk("exec_cycle", 64'(exec_cyc), 64'(exp_exec_cyc));
      end
   endtask

   initial begin
      int n;
      do_reset();
      chk("ready_after_rst", 64'(in_ready), 64'd1);

      frame_words = '{32'h92E00000, 32'h36F7000D};
      repeat (4) frame_words.push_back($urandom);
      run_frame(6, 0, 1'b1);
      do_reset();
      run_frame(6, 3, 1'b1);
      do_reset();

      run_frame(0, 0, 1'b1);
      do_reset();
      run_frame(513, 0, 1'b1);
      do_reset();

      repeat (4) begin
         n = $urandom_range(1, 8);
         frame_words.delete();
         repeat (n) frame_words.push_back($urandom);
         run_frame(n, 3, 1'b1);
         do_reset();
      end

      frame_words.delete();
      repeat (512) frame_words.push_back($urandom);
      run_frame(512, 0, 1'b1);
      do_reset();

      send_g(8'h00, 0);
      send_g(8'h01, 0);
      send_g(8'h92, 0);
      send_g(8'hE0, 0);
      repeat (3) @(negedge clk);
      chk("aborted_word_no_we", 64'(we_cnt), 64'd0);
      do_reset();
      frame_words = '{32'hDEADBEEF};
      run_frame(1, 1, 1'b1);
      do_reset();

      if (CSUM_EN) begin
         frame_words = '{32'h0000002A};
         run_frame(1, 0, 1'b0);
         do_reset();
         run_frame(1, 0, 1'b1);
         do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

endmodule
